// File: rtl/tpu_skew_feeder_if.sv
// rtl/tpu_skew_feeder_if.sv - stream/status bundle between the skew feeder and its driver
interface tpu_skew_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4
);
  logic                          in_valid;
  logic                          in_last;
  logic [LANES*DATA_WIDTH-1:0]   in_data;
  logic [LANES*DATA_WIDTH-1:0]   out_data;
  logic [LANES-1:0]              out_valid;
  logic                          busy;
  logic                          done;
  logic                          err;

  modport master (
    output in_valid, in_last, in_data,
    input  out_data, out_valid, busy, done, err
  );

  modport slave (
    input  in_valid, in_last, in_data,
    output out_data, out_valid, busy, done, err
  );
endinterface

// File: rtl/tpu_skew_feeder.sv
// rtl/tpu_skew_feeder.sv - diagonal input skew for the systolic array; SKEW_ZERO_FILL_EN zero-pads invalid lane slots
module tpu_skew_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4
) (
  input  logic              clk,
  input  logic              aclr_n,
  tpu_skew_feeder_if.slave  bus
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          accept;

  // Anything offered while draining is dropped so the wavefront stays aligned.
  assign accept = bus.in_valid && (state_q != S_DRAIN);

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (bus.in_valid && (state_q == S_DRAIN)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE, S_STREAM: begin
          if (bus.in_valid) begin
            if (bus.in_last) begin
              state_q <= S_DRAIN;
              cnt_q   <= LAST_CNT;
            end else begin
              state_q <= S_STREAM;
            end
          end
        end
        S_DRAIN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DRAIN) && (cnt_q == '0);
  assign bus.err  = err_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic                  v_q [k+1];
    logic [DATA_WIDTH-1:0] d_q [k+1];
    logic [DATA_WIDTH-1:0] lane_in;

    assign lane_in = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
        for (int j = 0; j <= k; j++) begin
          v_q[j] <= 1'b0;
          d_q[j] <= '0;
        end
      end else begin
        v_q[0] <= accept;
        for (int j = 1; j <= k; j++) begin
          v_q[j] <= v_q[j-1];
        end
`ifdef SKEW_ZERO_FILL_EN
        d_q[0] <= lane_in & {DATA_WIDTH{accept}};
        for (int j = 1; j <= k; j++) begin
          d_q[j] <= d_q[j-1] & {DATA_WIDTH{v_q[j-1]}};
        end
`else
        // Data stages hold through bubbles to avoid needless toggling.
        if (accept) begin
          d_q[0] <= lane_in;
        end
        for (int j = 1; j <= k; j++) begin
          if (v_q[j-1]) begin
            d_q[j] <= d_q[j-1];
          end
        end
`endif
      end
    end

    assign bus.out_valid[k]                        = v_q[k];
    assign bus.out_data[k*DATA_WIDTH +: DATA_WIDTH] = d_q[k];
  end

endmodule

// File: tb/tb_tpu_skew_feeder.sv
// tb/tb_tpu_skew_feeder.sv - randomized and directed bench for tpu_skew_feeder (LANES=4 and LANES=1 instances)
module tb_tpu_skew_feeder;

  localparam int DW   = 8;
  localparam int LN   = 4;
  localparam int MAXC = 2048;

  logic clk;
  logic aclr_n;

  tpu_skew_feeder_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();
  tpu_skew_feeder_if #(.DATA_WIDTH(16), .LANES(1))  bus1 ();

  tpu_skew_feeder #(.DATA_WIDTH(DW), .LANES(LN)) dut (
    .clk    (clk),
    .aclr_n (aclr_n),
    .bus    (bus)
  );

  tpu_skew_feeder #(.DATA_WIDTH(16), .LANES(1)) dut1 (
    .clk    (clk),
    .aclr_n (aclr_n),
    .bus    (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-cycle record of what was accepted, plus stream bookkeeping.
  logic          hv [MAXC];
  logic [31:0]   hd [MAXC];
  int            cyc       = 0;
  int            reset_cyc = 0;
  int            drain_end = -1;
  logic          open_e    = 1'b0;
  logic          err_e     = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [LN-1:0]    ev;
    logic [LN*DW-1:0] ed;
    int               s;
    for (int k = 0; k < LN; k++) begin
      s = cyc - 1 - k;
      ev[k] = (s >= reset_cyc) && (s >= 0) && hv[s];
      ed[k*DW +: DW] = '0;
`ifdef SKEW_ZERO_FILL_EN
      if (ev[k]) ed[k*DW +: DW] = hd[s][k*DW +: DW];
`else
      for (int u = s; u >= reset_cyc && u >= 0; u--) begin
        if (hv[u]) begin
          ed[k*DW +: DW] = hd[u][k*DW +: DW];
          break;
        end
      end
`endif
    end
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(ev));
    chk({tag, "_out_data"},  64'(bus.out_data),  64'(ed));
    chk({tag, "_busy"},      64'(bus.busy),      64'(open_e || (cyc <= drain_end)));
    chk({tag, "_done"},      64'(bus.done),      64'(cyc == drain_end));
    chk({tag, "_err"},       64'(bus.err),       64'(err_e));
  endtask

  task automatic step(input logic v, input logic l, input logic [31:0] d, input string tag);
    logic blocked;
    logic acc;
    bus.in_valid = v;
    bus.in_last  = l;
    bus.in_data  = d;
    blocked = (cyc <= drain_end);
    acc     = v && !blocked;
    if (v && blocked) err_e = 1'b1;
    hv[cyc] = acc;
    hd[cyc] = d;
    if (acc && l) begin
      drain_end = cyc + LN;
      open_e    = 1'b0;
    end else if (acc) begin
      open_e = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_data"},  64'(bus.out_data),  64'd0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_busy"},      64'(bus.busy),      64'd0);
    chk({tag, "_done"},      64'(bus.done),      64'd0);
    chk({tag, "_err"},       64'(bus.err),       64'd0);
  endtask

  task automatic do_reset(input int n, input string tag);
    aclr_n       = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    bus.in_data  = 32'hFFFF_FFFF;
    #1;
    check_zero({tag, "_async"});
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      check_zero({tag, "_hold"});
    end
    aclr_n       = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    reset_cyc    = cyc;
    drain_end    = -1;
    open_e       = 1'b0;
    err_e        = 1'b0;
  endtask

  initial begin
    aclr_n        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus1.in_valid = 1'b0;
    bus1.in_last  = 1'b0;
    bus1.in_data  = '0;

    // Reset with live input must keep every output at zero.
    do_reset(3, "rst0");

    // Single last vector: wavefront plus done on the final lane.
    step(1'b1, 1'b1, 32'h4433_2211, "single");
    chk("single_lane0", 64'(bus.out_data[7:0]), 64'h11);
    step(1'b0, 1'b0, 32'h0, "single");
    step(1'b0, 1'b0, 32'h0, "single");
    step(1'b0, 1'b0, 32'h0, "single");
    chk("single_lane3", 64'(bus.out_data[31:24]), 64'h44);
    chk("single_done",  64'(bus.done), 64'd1);
    step(1'b0, 1'b0, 32'h0, "single");
    chk("single_idle",  64'(bus.busy), 64'd0);

    // Back-to-back stream of three.
    step(1'b1, 1'b0, 32'h0303_0303, "b2b");
    step(1'b1, 1'b0, 32'h0202_0202, "b2b");
    step(1'b1, 1'b1, 32'h0101_0101, "b2b");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, "b2b");

    // Bubble between two vectors.
    step(1'b1, 1'b0, $urandom, "bubble");
    step(1'b0, 1'b0, $urandom, "bubble");
    step(1'b1, 1'b1, $urandom, "bubble");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, $urandom, "bubble");

    // Overrun in the done cycle, then a vector immediately after.
    step(1'b1, 1'b1, $urandom, "overrun");
    for (int i = 0; i < LN - 1; i++) step(1'b0, 1'b0, 32'h0, "overrun");
    chk("overrun_done_cycle", 64'(bus.done), 64'd1);
    step(1'b1, 1'b0, 32'hDEAD_BEEF, "overrun");
    chk("overrun_err", 64'(bus.err), 64'd1);
    step(1'b1, 1'b1, $urandom, "overrun");
    for (int i = 0; i < LN + 2; i++) step(1'b0, 1'b0, 32'h0, "overrun");
    chk("overrun_err_sticky", 64'(bus.err), 64'd1);

    do_reset(1, "rst1");

    // Randomized traffic with random bubbles, ends and overruns.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 6) == 0), $urandom, "rand");
    end
    for (int i = 0; i < LN + 2; i++) step(1'b0, 1'b0, 32'h0, "rand_tail");

    do_reset(1, "rst2");

    // Reset two cycles into DRAIN: in-flight data vanishes and done never fires.
    step(1'b1, 1'b0, $urandom, "middrain");
    step(1'b1, 1'b1, $urandom, "middrain");
    step(1'b0, 1'b0, 32'h0, "middrain");
    do_reset(1, "rst_mid");
    for (int i = 0; i < LN + 2; i++) step(1'b0, 1'b0, 32'h0, "post_mid");

    // Single-lane instance: everything lands one cycle after acceptance.
    bus1.in_valid = 1'b1;
    bus1.in_last  = 1'b1;
    bus1.in_data  = 16'hBEEF;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    bus1.in_last  = 1'b0;
    bus1.in_data  = 16'h0;
    chk("l1_data",  64'(bus1.out_data),  64'hBEEF);
    chk("l1_valid", 64'(bus1.out_valid), 64'd1);
    chk("l1_done",  64'(bus1.done),      64'd1);
    chk("l1_busy",  64'(bus1.busy),      64'd1);
    @(posedge clk);
    #1;
    chk("l1_valid_after", 64'(bus1.out_valid), 64'd0);
    chk("l1_done_after",  64'(bus1.done),      64'd0);
    chk("l1_busy_after",  64'(bus1.busy),      64'd0);
    chk("l1_err",         64'(bus1.err),       64'd0);
`ifdef SKEW_ZERO_FILL_EN
    chk("l1_data_after",  64'(bus1.out_data),  64'h0);
`else
    chk("l1_data_after",  64'(bus1.out_data),  64'hBEEF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tpu_skew_feeder.md
# tpu_skew_feeder

Input-skew stage for the TPU systolic array: accepts one LANES-wide vector per cycle and presents lane k delayed by k additional cycles, producing the diagonal wavefront the array expects. It sits upstream of the array's per-row 2-stage asynchronous-clear delay registers and feeds them directly. A small sequencer tracks stream boundaries, drains the skew pipeline after the last vector, and signals completion.

## Interface
- DATA_WIDTH, 8, bits per lane element
- LANES, 4, number of lanes (≥1); lane k total latency = k+1 cycles

- clk  in  1  rising-edge clock
- aclr_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data/in_last qualify this cycle
- in_last  in  1  final vector of the stream; ignored unless in_valid=1
- in_data  in  LANES*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- out_data  out  LANES*DATA_WIDTH  skewed lanes, same packing
- out_valid  out  LANES  out_valid[k] qualifies lane k of out_data
- busy  out  1  sequencer not IDLE
- done  out  1  one-cycle pulse coincident with the final out_valid[LANES-1]
- err  out  1  sticky: in_valid seen while DRAIN; cleared only by reset

## Operation
- Lane k: shift register of depth k+1 carrying {valid, data}; stage 0 registers in_valid/in_data every cycle.
- Acceptance: a vector is accepted when in_valid=1 and state ∈ {IDLE, STREAM}. In DRAIN, in_valid is dropped: nothing enters any lane (valid bit 0 enters) and err sets.
- Bubbles: in_valid=0 in STREAM is legal; the invalid slot propagates as out_valid[k]=0 k+1 cycles later.
- FSM states IDLE, STREAM, DRAIN; 2-bit state plus a counter of ceil(log2(LANES)) bits (min 1).
  - IDLE: accept with in_last=0 → STREAM; accept with in_last=1 → DRAIN, cnt←LANES-1.
  - STREAM: accept with in_last=1 → DRAIN, cnt←LANES-1; otherwise stay.
  - DRAIN: cnt≠0 → cnt−1; cnt=0 → IDLE.
- done = (state==DRAIN && cnt==0), combinational from registers.
- busy = (state≠IDLE).
- No arithmetic on data; lanes are passed bit-exact.

## Timing
- Vector accepted in cycle c: lane k visible on out_data with out_valid[k]=1 in cycle c+1+k.
- Last vector accepted in cycle c: DRAIN during c+1..c+LANES, done=1 in cycle c+LANES, IDLE in c+LANES+1; next vector accepted no earlier than c+LANES+1 (in_valid in the done cycle is dropped and sets err).
- LANES=1: last accepted in c → done in c+1 with out_valid[0].
- Reset (asynchronous assert, synchronous-to-clk deassert by system): out_data=0, out_valid=0, busy=0, done=0, err=0, state IDLE, cnt=0, all lane stages cleared. Reset mid-stream discards all in-flight vectors; no done is produced.
- Throughput: one vector per cycle in IDLE/STREAM.

## Configuration
- SKEW_ZERO_FILL_EN defined: every lane stage loads data&{DATA_WIDTH{valid}}, so out_data lane k is 0 whenever out_valid[k]=0 (zero padding for the array's MACs).
- Not defined: lane data stages load only when their incoming valid=1 and otherwise hold; out_data lane k holds the last valid value while out_valid[k]=0 (lower toggle power). Valid bits shift unconditionally in both builds.

## Test plan
- Reset: hold aclr_n=0 while driving in_valid=1, in_data=0xFFFFFFFF → all outputs 0, busy=0; release, drive 0x44332211 with in_last=1 in cycle c → lane0=0x11 at c+1, lane1=0x22 at c+2, lane2=0x33 at c+3, lane3=0x44 at c+4 with done=1, busy=0 at c+5.
- Stream of 3 back-to-back vectors 0x03030303, 0x02020202, 0x01010101 (last) starting cycle c → out_valid[3] high c+4..c+6, lane3 values 03,02,01; done only at c+6.
- Bubble: vectors at c and c+2 (last at c+2) → out_valid[2] pattern 1,0,1 in c+3..c+5; with SKEW_ZERO_FILL_EN lane2=0x00 at c+4, without it lane2 holds the c value.
- Overrun: in_valid=1 in the done cycle → vector absent from outputs, err=1 and stays 1 until reset; a vector one cycle later is accepted normally.
- Reset mid-DRAIN: assert aclr_n=0 at c+2 after last at c → out_valid=0 immediately, done never pulses, state IDLE.
- LANES=1, DATA_WIDTH=16: single vector 0xBEEF last at c → out_data=0xBEEF, out_valid=1, done=1 all in c+1.
